// File: rtl/dm_bytelane_pkg.sv
// dm_pkg: access-size and FSM types plus lane helpers shared by dm_bytelane.
package dm_pkg;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_BAD} size_e;
  typedef enum logic {ST_INIT, ST_RUN} state_e;
  function automatic logic [3:0] byte_mask(size_e size, logic [1:0] off);
    return size == SZ_B ? 4'b0001 << off : size == SZ_H ? 4'b0011 << off : size == SZ_W ? 4'b1111 : 4'b0000;
  endfunction
  function automatic logic is_misaligned(size_e size, logic [1:0] off);
    return (size == SZ_H && off[0]) || (size == SZ_W && off != 2'd0);
  endfunction
endpackage

// File: rtl/dm_lane_align.sv
// dm_lane_align: store-side lane replication/byte enables and load-side extract/extend.
module dm_lane_align
  import dm_pkg::*;
(
  input  size_e       st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] wdata,
  output logic [31:0] wdata_rep,
  output logic [3:0]  be,
  input  size_e       ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_unsigned,
  input  logic [31:0] rword,
  output logic [31:0] rdata
);
  logic [31:0] sh;
  always_comb begin
    wdata_rep = st_size == SZ_B ? {4{wdata[7:0]}} : st_size == SZ_H ? {2{wdata[15:0]}} : wdata;
    be = byte_mask(st_size, st_off);
    sh = rword >> {ld_off, 3'b000};
    rdata = ld_size == SZ_B ? {{24{~ld_unsigned & sh[7]}}, sh[7:0]} :
            ld_size == SZ_H ? {{16{~ld_unsigned & sh[15]}}, sh[15:0]} : sh;
  end
endmodule

// File: rtl/dm_bytelane.sv
// dm_bytelane: byte/half/word data memory with init sequencer and fixed-latency responses.
module dm_bytelane
  import dm_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 256,
  parameter int RD_LAT      = 1,
  parameter int INIT_ON_RST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_busy
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] mem [DEPTH];
  state_e state, state_n;
  logic [AW-1:0] idx, idx_n, addr_m;
  logic acc, err, v1, e1, w1, u1, er1;
  logic [31:0] wrep, wd, rd_q, ext, r1;
  logic [3:0] be, wbe;
  logic [1:0] off1;
  size_e size, sz1;
  assign size = size_e'(req_size);
  assign req_ready = state == ST_RUN && !rst;
  assign init_busy = state == ST_INIT;
  assign acc = req_valid && req_ready;
  assign err = size == SZ_BAD || is_misaligned(size, req_addr[1:0]) || (req_addr >> 2) >= ADDR_W'(DEPTH);
  // The init sequencer and requests share the single array port.
  assign addr_m = init_busy ? idx : req_addr[AW+1:2];
  assign wd = init_busy ? 32'(idx) : wrep;
  assign wbe = init_busy && INIT_ON_RST != 0 ? 4'hf : acc && req_we && !err ? be : 4'h0;
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (wbe[i]) mem[addr_m][8*i +: 8] <= wd[8*i +: 8];
    rd_q <= mem[addr_m];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
      idx <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
    end
  end
  always_comb begin
    state_n = state;
    idx_n = idx;
    if (state == ST_INIT) begin
      idx_n = idx + 1'b1;
      state_n = INIT_ON_RST == 0 || idx == AW'(DEPTH - 1) ? ST_RUN : ST_INIT;
    end
  end
  // acc is already low during rst, so this flushes the first stage too.
  always_ff @(posedge clk) begin
    v1 <= acc;
    e1 <= err;
    w1 <= req_we;
    sz1 <= size;
    off1 <= req_addr[1:0];
    u1 <= req_unsigned;
  end
  dm_lane_align u_align (
    .st_size(size), .st_off(req_addr[1:0]), .wdata(req_wdata), .wdata_rep(wrep), .be(be),
    .ld_size(sz1), .ld_off(off1), .ld_unsigned(u1), .rword(rd_q), .rdata(ext)
  );
  assign r1 = v1 && !e1 && !w1 ? ext : '0;
  assign er1 = v1 && e1;
  if (RD_LAT == 2) begin : g_lat2
    logic v2, e2;
    logic [31:0] d2;
    always_ff @(posedge clk) begin
      v2 <= v1 && !rst;
      e2 <= er1 && !rst;
      d2 <= rst ? '0 : r1;
    end
    assign rsp_valid = v2;
    assign rsp_err = e2;
    assign rsp_rdata = d2;
  end else begin : g_lat1
    assign rsp_valid = v1;
    assign rsp_err = er1;
    assign rsp_rdata = r1;
  end
endmodule

// File: tb/tb_dm_bytelane.sv
// tb_dm_bytelane: directed checks of dm_bytelane at RD_LAT 1 and 2 against a byte-level model.
module tb_dm_bytelane;
  logic clk = 0, rst = 1, req_valid = 0, req_we = 0, req_unsigned = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [1:0] req_size = 0;
  logic rdy1, rv1, re1, ib1, rdy2, rv2, re2, ib2;
  logic [31:0] rd1, rd2;
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;

  dm_bytelane #(.RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(re1), .init_busy(ib1)
  );
  dm_bytelane #(.RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy2), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(rv2), .rsp_rdata(rd2), .rsp_err(re2), .init_busy(ib2)
  );

  typedef struct packed {logic v; logic [31:0] d; logic e;} rsp_t;
  rsp_t p1 = '0, p2 = '0;
  logic [31:0] m [256];
  bit mbusy = 1;
  int cnt = 256;

  task automatic model_step();
    bit acc;
    rsp_t r;
    int n;
    logic [63:0] w;
    acc = req_valid && !rst && !mbusy;
    r = '0;
    if (acc) begin
      n = req_size == 0 ? 1 : req_size == 1 ? 2 : 4;
      r.v = 1;
      r.e = req_size == 3 || req_addr % n != 0 || req_addr / 4 >= 256;
      if (!r.e && req_we) begin
        for (int b = 0; b < n; b++)
          m[(req_addr + b) / 4][8 * ((req_addr + b) % 4) +: 8] = req_wdata[8 * b +: 8];
      end else if (!r.e) begin
        w = 64'(m[req_addr / 4]) >> (8 * (req_addr % 4));
        w = w % (64'd1 << (8 * n));
        if (!req_unsigned && n < 4 && w >= (64'd1 << (8 * n - 1)))
          w = w + (64'd1 << 32) - (64'd1 << (8 * n));
        r.d = w[31:0];
      end
    end
    if (rst) begin
      p1 = '0;
      p2 = '0;
      mbusy = 1;
      cnt = 256;
    end else begin
      p2 = p1;
      p1 = r;
      if (mbusy) begin
        cnt--;
        if (cnt == 0) begin
          mbusy = 0;
          for (int i = 0; i < 256; i++) m[i] = i;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("ready1", rdy1, !rst && !mbusy);
      chk("busy1", ib1, mbusy);
      chk("valid1", rv1, p1.v);
      chk("err1", re1, p1.v && p1.e);
      chk("rdata1", rd1, p1.v ? p1.d : 32'h0);
      chk("ready2", rdy2, !rst && !mbusy);
      chk("busy2", ib2, mbusy);
      chk("valid2", rv2, p2.v);
      chk("err2", re2, p2.v && p2.e);
      chk("rdata2", rd2, p2.v ? p2.d : 32'h0);
    end
  end

  task automatic req(bit we, logic [31:0] addr, logic [1:0] size, bit uns, logic [31:0] wdata);
    req_we = we;
    req_addr = addr;
    req_size = size;
    req_unsigned = uns;
    req_wdata = wdata;
    req_valid = 1;
    @(posedge clk);
    #2 req_valid = 0;
  endtask

  task automatic lit(string nm, logic [31:0] d, bit e);
    @(negedge clk);
    chk({nm, " valid"}, rv1, 1);
    chk({nm, " data"}, rd1, d);
    chk({nm, " err"}, re1, e);
    chk({nm, " model"}, p1.d, d);
    @(posedge clk);
    #2;
  endtask

  task automatic wait_init();
    for (int i = 0; i < 1000 && ib1; i++) @(negedge clk);
    chk("init timeout", ib1, 0);
    @(posedge clk);
    #2;
  endtask

  initial begin
    int c;
    repeat (2) @(posedge clk);
    #2 rst = 0;
    c = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!ib1) break;
      c++;
    end
    chk("init cycles", c, 256);
    @(posedge clk);
    #2;
    req(0, 'h14, 2, 0, 0);          lit("lw14", 32'h5, 0);
    req(1, 'h21, 0, 0, 'h80);       lit("sb21", 32'h0, 0);
    req(0, 'h20, 2, 0, 0);          lit("lw20", 32'h8008, 0);
    req(0, 'h21, 0, 0, 0);          lit("lb21", 32'hFFFFFF80, 0);
    req(0, 'h21, 0, 1, 0);          lit("lbu21", 32'h80, 0);
    req(1, 'h42, 1, 0, 'hBEEF);     lit("sh42", 32'h0, 0);
    req(0, 'h40, 2, 0, 0);          lit("lw40", 32'hBEEF0010, 0);
    req(0, 'h42, 1, 0, 0);          lit("lh42", 32'hFFFFBEEF, 0);
    req(0, 'h42, 1, 1, 0);          lit("lhu42", 32'hBEEF, 0);
    req(0, 'h42, 0, 0, 0);          lit("lb42", 32'hFFFFFFEF, 0);
    req(0, 'h40, 1, 1, 0);          lit("lhu40", 32'h10, 0);
    req(1, 'h06, 2, 0, 'hDEADBEEF); lit("sw06", 32'h0, 1);
    req(0, 'h04, 2, 0, 0);          lit("lw04", 32'h1, 0);
    req(0, 'h03, 1, 0, 0);          lit("lh03", 32'h0, 1);
    req(0, 'h400, 2, 0, 0);         lit("lw400", 32'h0, 1);
    req(0, 'h00, 3, 0, 0);          lit("size3", 32'h0, 1);
    req(1, 'h3FF, 0, 0, 'h77);      lit("sb3ff", 32'h0, 0);
    req(0, 'h3FF, 0, 1, 0);         lit("lbu3ff", 32'h77, 0);
    req(0, 'h3FC, 2, 0, 0);         lit("lw3fc", 32'h770000FF, 0);
    req_we = 1; req_addr = 'h10; req_size = 2; req_wdata = 32'hA5A5A5A5; req_valid = 1;
    @(posedge clk);
    #2 req_we = 0;
    @(negedge clk);
    chk("b2b early", rv2, 0);
    @(posedge clk);
    #2 req_valid = 0;
    @(negedge clk);
    chk("b2b st valid", rv2, 1);
    chk("b2b st data", rd2, 0);
    @(posedge clk);
    #2;
    @(negedge clk);
    chk("b2b ld valid", rv2, 1);
    chk("b2b ld data", rd2, 32'hA5A5A5A5);
    @(posedge clk);
    #2;
    req_we = 0; req_addr = 'h10; req_size = 2; req_valid = 1;
    @(posedge clk);
    #2 req_valid = 0;
    rst = 1;
    @(negedge clk);
    chk("rst flush a", rv2, 0);
    @(posedge clk);
    #2;
    @(negedge clk);
    chk("rst flush b", rv2, 0);
    @(posedge clk);
    #2 rst = 0;
    wait_init();
    req(0, 'h10, 2, 0, 0);          lit("lw10 reinit", 32'h4, 0);
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at %0t", $time);
    $fatal(1);
  end
endmodule
